bist_sequencer: RTL

- Sequences a test-per-scan BIST session around the circuit-under-test scan chain, the input LFSR and the output MISR.
- Session order: seed the LFSR and clear the MISR, then run NUM_PATTERNS rounds of shift (CHAIN_LEN cycles) plus capture (1 cycle), then flush the chain and compare the MISR signature against a golden value.
- Drives scan_en (which also controls the functional/test input mux), the LFSR seed load, the MISR clear, and the finish/bist_end/pass_fail status.
- Sits between the top-level bist_start pin and the LFSR, MISR and scan datapath.

---
 rtl/bist_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: test-per-scan BIST session sequencer (seed, shift/capture rounds, flush, signature compare).
// Optional BIST_RETRY_EN: a failing first compare reruns the session once before reporting.
module bist_sequencer #(
    parameter int CHAIN_LEN    = 8,
    parameter int NUM_PATTERNS = 1000,
    parameter int CNT_W        = 16,
    parameter int SIG_W        = 10,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] hf,
    output logic             scan_en,
    output logic             seed,
    output logic             misr_clr,
    output logic             running,
    output logic             finish,
    output logic             bist_end,
    output logic             pass_fail
);
    localparam int SC_W = $clog2(CHAIN_LEN + 1);

    if ((NUM_PATTERNS >> CNT_W) != 0) begin : g_cnt_w_check
        $error("bist_sequencer: CNT_W too small for NUM_PATTERNS");
    end

    typedef enum logic [2:0] {IDLE, SEED, SHIFT, CAPTURE, FLUSH, COMPARE, DONE} state_t;

    state_t st, nxt;
    logic [SC_W-1:0] sc;
    logic [CNT_W-1:0] pc;
    logic sc_last, pc_last, match, retry_ok;

    assign sc_last = sc == SC_W'(CHAIN_LEN - 1);
    assign pc_last = (pc + CNT_W'(1)) == CNT_W'(NUM_PATTERNS);
    assign match   = hf == GOLDEN_SIG;

`ifdef BIST_RETRY_EN
    logic retried;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            retried <= 1'b0;
        else if (st == IDLE)
            retried <= 1'b0;
        else if (st == COMPARE)
            retried <= 1'b1;
    end
    assign retry_ok = !retried;
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            st <= IDLE;
        else
            st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? SEED : IDLE;
            SEED:    nxt = SHIFT;
            SHIFT:   nxt = sc_last ? CAPTURE : SHIFT;
            CAPTURE: nxt = pc_last ? FLUSH : SHIFT;
            FLUSH:   nxt = sc_last ? COMPARE : FLUSH;
            COMPARE: nxt = (!match && retry_ok) ? SEED : DONE;
            DONE:    nxt = start ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
        if (abort)
            nxt = IDLE;
    end

    // pass_fail clears as a session (or retry) enters SEED so a stale result never overlaps a new run
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sc        <= '0;
            pc        <= '0;
            pass_fail <= 1'b0;
        end else begin
            if (abort || st == SEED) begin
                sc <= '0;
                pc <= '0;
            end else if (st == SHIFT || st == FLUSH) begin
                sc <= sc_last ? '0 : sc + SC_W'(1);
            end else if (st == CAPTURE) begin
                pc <= pc + CNT_W'(1);
            end
            if (abort || nxt == SEED)
                pass_fail <= 1'b0;
            else if (st == COMPARE)
                pass_fail <= match;
        end
    end

    assign scan_en  = st == SHIFT || st == FLUSH;
    assign seed     = st == SEED;
    assign misr_clr = st == SEED;
    assign running  = st != IDLE && st != DONE;
    assign finish   = st == COMPARE;
    assign bist_end = st == DONE;
endmodule
